// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer arbiter and its back-FIFO sizing.
package fb_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } fb_state_e;

  localparam int FRAME_PIXELS_DEFAULT = 307200;
  localparam int READ_LATENCY         = 2;
endpackage

// File: rtl/fb_arbiter_if.sv
// Port bundle between the frame-buffer arbiter, the pipeline, the BRAM and the back-FIFO.
interface fb_arbiter_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
);
  import fb_pkg::*;

  // Handshakes: i_valid is a push with no ready (a write is never refused);
  // o_wr is a push into the back-FIFO with no ready, throttled only through
  // i_almostfull, which must leave room for READ_LATENCY reads already in flight.
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_req;
  logic                  i_almostfull;
  logic                  o_wr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  o_bram_en;
  logic                  o_bram_we;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic [DATA_WIDTH-1:0] o_bram_wdata;
  logic [DATA_WIDTH-1:0] i_bram_rdata;
  logic                  o_frame_done;
  logic [15:0]           o_defer_cnt;
  fb_state_e             o_state;

  modport master (
    input  i_valid, i_data, i_req, i_almostfull, i_bram_rdata,
    output o_wr, o_wdata, o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata,
    output o_frame_done, o_defer_cnt, o_state
  );

  modport slave (
    output i_valid, i_data, i_req, i_almostfull, i_bram_rdata,
    input  o_wr, o_wdata, o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata,
    input  o_frame_done, o_defer_cnt, o_state
  );
endinterface

// File: rtl/fb_arbiter_addr_counter.sv
// Modulo-N address counter with enable and synchronous clear (clear wins).
module fb_addr_counter #(
  parameter int N = 307200,
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == W'(N - 1)) ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: pipeline writes always win, frame read-out fills the back-FIFO.
// Optional read-defer statistics counter is built only when FB_ARB_STATS_EN is defined.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
  parameter int ADDR_WIDTH   = 19
) (
  input logic          i_clk,
  input logic          i_rstn,
  fb_arbiter_if.master bus
);
  fb_state_e               state, state_next;
  logic                    req_q;
  logic                    rise;
  logic                    rd_issue;
  logic                    last_issue;
  logic                    rptr_clr;
  logic                    done_flag;
  logic                    fire;
  logic                    frame_done_q;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [ADDR_WIDTH-1:0]   wptr, rptr;

  assign rise       = bus.i_req & ~req_q;
  assign rd_issue   = (state == S_READ) && !bus.i_almostfull && !bus.i_valid;
  assign last_issue = rd_issue && (rptr == ADDR_WIDTH'(FRAME_PIXELS - 1));
  assign rptr_clr   = rise && (state != S_DONE);
  // Frame is complete once no read is left ahead of the output register.
  assign fire       = (state == S_DONE) && (rd_pipe[READ_LATENCY-2:0] == '0) && !done_flag;

  fb_addr_counter #(.N(FRAME_PIXELS), .W(ADDR_WIDTH)) u_wptr (
    .clk(i_clk), .rstn(i_rstn), .en(bus.i_valid), .clr(1'b0), .count(wptr)
  );

  fb_addr_counter #(.N(FRAME_PIXELS), .W(ADDR_WIDTH)) u_rptr (
    .clk(i_clk), .rstn(i_rstn), .en(rd_issue), .clr(rptr_clr), .count(rptr)
  );

  always_comb begin
    bus.o_bram_en    = 1'b0;
    bus.o_bram_we    = 1'b0;
    bus.o_bram_addr  = '0;
    bus.o_bram_wdata = '0;
    if (bus.i_valid) begin
      bus.o_bram_en    = 1'b1;
      bus.o_bram_we    = 1'b1;
      bus.o_bram_addr  = wptr;
      bus.o_bram_wdata = bus.i_data;
    end else if (rd_issue) begin
      bus.o_bram_en   = 1'b1;
      bus.o_bram_addr = rptr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (rise) state_next = S_READ;
      S_READ: begin
        if (rise)              state_next = S_READ;
        else if (!bus.i_req)   state_next = S_IDLE;
        else if (last_issue)   state_next = S_DONE;
      end
      S_DONE: if ((done_flag || fire) && !bus.i_req) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      req_q        <= 1'b0;
      rd_pipe      <= '0;
      wdata_q      <= '0;
      done_flag    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      req_q        <= bus.i_req;
      rd_pipe      <= {rd_pipe[READ_LATENCY-2:0], rd_issue};
      if (rd_pipe[READ_LATENCY-2]) wdata_q <= bus.i_bram_rdata;
      done_flag    <= (state_next == S_DONE) && (done_flag || fire);
      frame_done_q <= fire;
    end
  end

  assign bus.o_wr         = rd_pipe[READ_LATENCY-1];
  assign bus.o_wdata      = wdata_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_state      = state;

`ifdef FB_ARB_STATS_EN
  logic [15:0] defer_q;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      defer_q <= '0;
    end else if ((state == S_READ) && !bus.i_almostfull && bus.i_valid && (defer_q != 16'hFFFF)) begin
      defer_q <= defer_q + 16'd1;
    end
  end
  assign bus.o_defer_cnt = defer_q;
`else
  assign bus.o_defer_cnt = '0;
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// Randomised self-checking bench for fb_arbiter against a frame-level reference model.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int DW = 12;
  localparam int AW = 7;
  localparam int N  = 100;
  localparam int BW = 1 + 1 + AW + DW + 1 + DW + 1 + 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fb_arbiter #(.DATA_WIDTH(DW), .FRAME_PIXELS(N), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .bus(bus)
  );

  // Behavioural single-port BRAM with one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.o_bram_en) begin
      if (bus.o_bram_we) mem[bus.o_bram_addr] <= bus.o_bram_wdata;
      else               bus.i_bram_rdata <= mem[bus.o_bram_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: frame-level view of the buffer and the read-out.
  logic [DW-1:0] ref_mem [0:N-1];
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  int            m_wptr, m_rptr, m_done_due, m_defer;
  bit            m_reading, m_draining, m_req_q;

  logic [BW-1:0] exp_bus, obs_bus;
  logic          obs_en, obs_we, obs_wr, obs_done;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_fd;
  logic [15:0]   obs_defer;

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_done_due = -1; m_defer = 0;
    m_reading = 0; m_draining = 0; m_req_q = 0;
    exp_q.delete(); due_q.delete();
  endtask

  // Applies one cycle of inputs, predicts and captures outputs, then advances the model.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic af);
    logic          e_en, e_we, e_wr, e_done, issue, rise, was_last;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_bwd, e_fd, o_bwd;
    logic [15:0]   e_def;
    bus.i_valid = v; bus.i_data = d; bus.i_req = r; bus.i_almostfull = af;
    e_en   = v || (m_reading && !af);
    e_we   = v;
    e_addr = !e_en ? '0 : (v ? m_wptr[AW-1:0] : m_rptr[AW-1:0]);
    e_bwd  = v ? d : '0;
    e_wr   = (due_q.size() > 0) && (due_q[0] == cyc);
    e_fd   = e_wr ? exp_q[0] : '0;
    e_done = (cyc == m_done_due);
`ifdef FB_ARB_STATS_EN
    e_def  = m_defer[15:0];
`else
    e_def  = 16'd0;
`endif
    exp_bus = {e_en, e_we, e_addr, e_bwd, e_wr, e_fd, e_done, e_def};
    @(negedge clk);
    obs_en    = bus.o_bram_en;
    obs_we    = bus.o_bram_we;
    obs_addr  = obs_en ? bus.o_bram_addr : '0;
    o_bwd     = obs_we ? bus.o_bram_wdata : '0;
    obs_wr    = bus.o_wr;
    obs_fd    = obs_wr ? bus.o_wdata : '0;
    obs_done  = bus.o_frame_done;
    obs_defer = bus.o_defer_cnt;
    obs_bus   = {obs_en, obs_we, obs_addr, o_bwd, obs_wr, obs_fd, obs_done, obs_defer};
    @(posedge clk); #1;
    if (e_wr) begin void'(exp_q.pop_front()); void'(due_q.pop_front()); end
    issue = !v && m_reading && !af;
    rise  = r && !m_req_q;
    m_req_q = r;
    if (m_reading && !af && v && m_defer < 16'hFFFF) m_defer++;
    if (v) begin ref_mem[m_wptr] = d; m_wptr = (m_wptr + 1) % N; end
    was_last = issue && (m_rptr == N - 1);
    if (issue) begin
      exp_q.push_back(ref_mem[m_rptr]);
      due_q.push_back(cyc + 2);
      m_rptr = (m_rptr + 1) % N;
    end
    if (m_reading) begin
      if (rise) m_rptr = 0;
      else if (!r) m_reading = 0;
      else if (was_last) begin m_reading = 0; m_draining = 1; m_done_due = cyc + 3; end
    end else if (m_draining) begin
      if (cyc >= m_done_due - 1 && !r) m_draining = 0;
    end else if (rise) begin
      m_reading = 1; m_rptr = 0;
    end
    cyc++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.i_valid = 0; bus.i_data = '0; bus.i_req = 0; bus.i_almostfull = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.o_wr, bus.o_wdata, bus.o_bram_en, bus.o_bram_we, bus.o_bram_addr, bus.o_bram_wdata,
         bus.o_frame_done, bus.o_defer_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b wd=%h en=%b we=%b addr=%h bwd=%h done=%b def=%h required all 0",
               bus.o_wr, bus.o_wdata, bus.o_bram_en, bus.o_bram_we, bus.o_bram_addr,
               bus.o_bram_wdata, bus.o_frame_done, bus.o_defer_cnt);
    end
    checks++;
    if (bus.o_state !== S_IDLE) begin
      errors++; $display("FAIL reset_state got %0d required %0d", bus.o_state, S_IDLE);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_write_stream();
    int we_cnt = 0;
    logic [AW-1:0] last_addr;
    for (int i = 0; i <= N; i++) begin
      drive(1'b1, DW'(i % N), 1'b0, 1'b0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL write_stream cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
      if (obs_we) we_cnt++;
      last_addr = obs_addr;
    end
    checks++;
    if (last_addr !== '0) begin
      errors++; $display("FAIL write_wrap_addr got %0d required 0", last_addr);
    end
    checks++;
    if (we_cnt != N + 1) begin
      errors++; $display("FAIL write_we_every_cycle got %0d required %0d", we_cnt, N + 1);
    end
  endtask

  task automatic test_frame_readout();
    int c0 = cyc, first_wr = -1, wr_cnt = 0, done_cnt = 0, tail = 0;
    bit seq_ok = 1;
    for (int i = 0; i < 3 * N && tail < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL frame_readout cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
      if (obs_wr) begin
        if (first_wr < 0) first_wr = cyc - 1;
        if (obs_fd !== DW'(wr_cnt)) seq_ok = 0;
        wr_cnt++;
      end
      if (obs_done) done_cnt++;
      if (done_cnt > 0) tail++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      if (obs_done) done_cnt++;
    end
    checks++;
    if (first_wr - c0 != 3) begin
      errors++; $display("FAIL first_wr_latency got %0d required 3", first_wr - c0);
    end
    checks++;
    if (wr_cnt != N || !seq_ok) begin
      errors++; $display("FAIL frame_wr_count got %0d (in order=%0d) required %0d in order", wr_cnt, seq_ok, N);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL frame_done_pulses got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_collision();
    int val_cnt = 0, wr_cnt = 0;
    bit seq_ok = 1;
    logic [15:0] def0 = obs_defer;
    for (int i = 0; i < 4 * N && (i < 2 || m_reading || m_draining); i++) begin
      logic v;
      v = i[0] && (i > 0);
      if (v && m_reading) val_cnt++;
      drive(v, DW'(m_wptr), 1'b1, 1'b0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL collision cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
      if (obs_wr) begin
        if (obs_fd !== DW'(wr_cnt)) seq_ok = 0;
        wr_cnt++;
      end
    end
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (wr_cnt != N || !seq_ok) begin
      errors++; $display("FAIL collision_contiguous got %0d (in order=%0d) required %0d", wr_cnt, seq_ok, N);
    end
    checks++;
`ifdef FB_ARB_STATS_EN
    if (obs_defer - def0 != 16'(val_cnt)) begin
      errors++; $display("FAIL defer_count got %0d required %0d", obs_defer - def0, val_cnt);
    end
`else
    if (obs_defer !== 16'd0 || def0 !== 16'd0) begin
      errors++; $display("FAIL defer_tied_off got %0d required 0 (valid cycles %0d)", obs_defer, val_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    int wr_cnt = 0, wr_after = 0, rd_during = 0;
    bit seq_ok = 1;
    for (int i = 0; i < 6 * N && (i < 2 || m_reading || m_draining); i++) begin
      logic v, af;
      v  = ($urandom_range(0, 3) == 0);
      af = (i >= 20 && i < 28) ? 1'b1 : ($urandom_range(0, 4) == 0);
      drive(v, DW'(m_wptr), 1'b1, af);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL backpressure cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
      if (i >= 20 && i < 28) begin
        if (obs_en && !obs_we) rd_during++;
        if (i > 20 && obs_wr) wr_after++;
      end
      if (obs_wr) begin
        if (obs_fd !== DW'(wr_cnt)) seq_ok = 0;
        wr_cnt++;
      end
    end
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (rd_during != 0 || wr_after > 2) begin
      errors++; $display("FAIL almostfull_hold got reads=%0d wr_after=%0d required reads=0 wr_after<=2", rd_during, wr_after);
    end
    checks++;
    if (wr_cnt != N || !seq_ok) begin
      errors++; $display("FAIL backpressure_resume got %0d (in order=%0d) required %0d", wr_cnt, seq_ok, N);
    end
  endtask

  task automatic test_resync();
    int issued = 0, first_addr = -1;
    for (int i = 0; i < 2 * N && issued < 30; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL resync_pre cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
      if (obs_en && !obs_we) issued++;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && first_addr < 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL resync_post cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
      if (obs_en && !obs_we) first_addr = int'(obs_addr);
    end
    checks++;
    if (first_addr != 0) begin
      errors++; $display("FAIL resync_addr got %0d required 0", first_addr);
    end
    repeat (4) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int wr_cnt = 0;
    for (int i = 0; i < 15; i++) drive(1'b0, '0, 1'b1, 1'b0);
    rstn = 1'b0;
    bus.i_valid = 0; bus.i_req = 0; bus.i_almostfull = 0;
    #1;
    checks++;
    if ({bus.o_wr, bus.o_wdata, bus.o_bram_en, bus.o_bram_we, bus.o_frame_done, bus.o_defer_cnt} !== '0) begin
      errors++; $display("FAIL midframe_async_reset got wr=%b wd=%h en=%b we=%b done=%b def=%h required all 0",
                         bus.o_wr, bus.o_wdata, bus.o_bram_en, bus.o_bram_we, bus.o_frame_done, bus.o_defer_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.o_wr, bus.o_bram_en, bus.o_bram_addr, bus.o_state} !== '0) begin
      errors++; $display("FAIL midframe_reset_edge got wr=%b en=%b addr=%h st=%0d required 0",
                         bus.o_wr, bus.o_bram_en, bus.o_bram_addr, bus.o_state);
    end
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL post_reset cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
      if (obs_wr) wr_cnt++;
    end
    checks++;
    if (wr_cnt != 0) begin
      errors++; $display("FAIL post_reset_wr got %0d required 0", wr_cnt);
    end
    // Rebuild a known frame so later reads see defined data.
    for (int i = 0; i < N; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic v, af;
      v  = ($urandom_range(0, 1) == 0);
      af = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) r = ~r;
      drive(v, DW'($urandom_range(0, (1 << DW) - 1)), r, af);
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++; $display("FAIL random cyc=%0d got=%h required=%h", cyc, obs_bus, exp_bus);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    model_reset();
    test_reset();
    test_write_stream();
    test_frame_readout();
    test_collision();
    test_backpressure();
    test_resync();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
